// File: rtl/tick_timer.sv
// Tick-driven countdown timer with one-shot/periodic modes and start/done/ack handshake.
// Optional pause input enabled by defining TICK_TIMER_PAUSE_EN.
module tick_timer #(
    parameter int TICKS_W = 8
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               tick,
    input  logic               start,
    input  logic [TICKS_W-1:0] load_val,
    input  logic               periodic,
    input  logic               stop,
`ifdef TICK_TIMER_PAUSE_EN
    input  logic               pause,
`endif
    input  logic               ack,
    output logic               busy,
    output logic               done,
    output logic               expire,
    output logic [TICKS_W-1:0] remaining
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TICKS_W-1:0] r_remaining;
    logic [TICKS_W-1:0] w_remaining_nxt;
    logic [TICKS_W-1:0] r_reload;
    logic [TICKS_W-1:0] w_reload_nxt;
    logic               r_periodic;
    logic               w_periodic_nxt;
    logic               r_expire;
    logic               w_expire_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_count;

`ifdef TICK_TIMER_PAUSE_EN
    assign w_count = tick & ~pause;
`else
    assign w_count = tick;
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_reload    <= '0;
            r_periodic  <= 1'b0;
            r_expire    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_reload    <= w_reload_nxt;
            r_periodic  <= w_periodic_nxt;
            r_expire    <= w_expire_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_reload_nxt    = r_reload;
        w_periodic_nxt  = r_periodic;
        w_expire_nxt    = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                // start in DONE doubles as ack and takes priority over it
                if (start) begin
                    w_reload_nxt   = load_val;
                    w_periodic_nxt = periodic;
                    if (|load_val) begin
                        w_state_nxt     = RUN;
                        w_remaining_nxt = load_val;
                    end else begin
                        w_state_nxt     = DONE;
                        w_remaining_nxt = '0;
                        w_expire_nxt    = 1'b1;
                    end
                end else if (r_state == DONE && ack) begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_nxt     = IDLE;
                    w_remaining_nxt = '0;
                end else if (w_count) begin
                    if (r_remaining > TICKS_W'(1)) begin
                        w_remaining_nxt = r_remaining - TICKS_W'(1);
                    end else begin
                        w_expire_nxt = 1'b1;
                        if (r_periodic) begin
                            w_remaining_nxt = r_reload;
                        end else begin
                            w_remaining_nxt = '0;
                            w_state_nxt     = DONE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_remaining_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_busy_nxt = (w_state_nxt == RUN);
        w_done_nxt = (w_state_nxt == DONE);
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign expire    = r_expire;
    assign remaining = r_remaining;

endmodule

// File: tb/tb_tick_timer.sv
// Directed scoreboard bench for tick_timer.
// Pause scenario runs only when TICK_TIMER_PAUSE_EN is defined.
module tb_tick_timer;

    logic       CLOCK_50;
    logic       resetn;
    logic       tick;
    logic       start;
    logic [7:0] load_val;
    logic       periodic;
    logic       stop;
    logic       pause;
    logic       ack;
    logic       busy;
    logic       done;
    logic       expire;
    logic [7:0] remaining;

    typedef struct {
        logic       b;
        logic       d;
        logic       e;
        logic [7:0] r;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    tick_timer #(.TICKS_W(8)) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .tick     (tick),
        .start    (start),
        .load_val (load_val),
        .periodic (periodic),
        .stop     (stop),
`ifdef TICK_TIMER_PAUSE_EN
        .pause    (pause),
`endif
        .ack      (ack),
        .busy     (busy),
        .done     (done),
        .expire   (expire),
        .remaining(remaining)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    task automatic push(input logic eb, input logic ed, input logic ee,
                        input logic [7:0] er, input string tag);
        exp_t x;
        x.b = eb; x.d = ed; x.e = ee; x.r = er; x.tag = tag;
        q.push_back(x);
    endtask

    task automatic pop_check();
        exp_t x;
        x = q.pop_front();
        n_cmp++;
        assert (busy === x.b) else begin
            n_err++;
            $error("FAIL %s busy got %0b want %0b", x.tag, busy, x.b);
        end
        n_cmp++;
        assert (done === x.d) else begin
            n_err++;
            $error("FAIL %s done got %0b want %0b", x.tag, done, x.d);
        end
        n_cmp++;
        assert (expire === x.e) else begin
            n_err++;
            $error("FAIL %s expire got %0b want %0b", x.tag, expire, x.e);
        end
        n_cmp++;
        assert (remaining === x.r) else begin
            n_err++;
            $error("FAIL %s remaining got %0d want %0d", x.tag, remaining, x.r);
        end
    endtask

    // drive one cycle of inputs, then check the registered outputs after the edge
    task automatic step(input logic t, input logic s, input logic st,
                        input logic a, input logic [7:0] lv, input logic per,
                        input logic eb, input logic ed, input logic ee,
                        input logic [7:0] er, input string tag);
        tick = t; start = s; stop = st; ack = a;
        load_val = lv; periodic = per;
        push(eb, ed, ee, er, tag);
        @(posedge CLOCK_50);
        #1;
        pop_check();
    endtask

    initial begin
        resetn = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0;
        ack = 1'b0; load_val = '0; periodic = 1'b0; pause = 1'b0;
        #3;
        push(0, 0, 0, 0, "reset");
        pop_check();
        @(negedge CLOCK_50);
        resetn = 1'b1;

        // tick in IDLE is ignored
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle_tick");

        // one-shot, 3 ticks spaced 5 cycles apart
        step(0, 1, 0, 0, 3, 0, 1, 0, 0, 3, "os_start");
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 4; w++)
                step(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'(3 - k), "os_wait");
            if (k < 2)
                step(1, 0, 0, 0, 0, 0, 1, 0, 0, 8'(2 - k), "os_tick");
            else
                step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, "os_final");
        end
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "os_done_hold");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "os_ack");

        // periodic, reload 2, six ticks
        step(0, 1, 0, 0, 2, 1, 1, 0, 0, 2, "per_start");
        for (int i = 1; i <= 6; i++) begin
            if (i % 2 == 0)
                step(1, 0, 0, 0, 0, 0, 1, 0, 1, 2, "per_expire");
            else
                step(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, "per_tick");
        end
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 2, "per_quiet");
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "per_stop");

        // stop beats tick at remaining==1
        step(0, 1, 0, 0, 2, 0, 1, 0, 0, 2, "stp_start");
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, "stp_tick");
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, "stp_both");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "stp_after");

        // zero load expires immediately
        step(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, "zero_start");
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "zero_hold");
        // restart from DONE with a coincident tick that must not count
        step(1, 1, 0, 0, 1, 0, 1, 0, 0, 1, "st_tick_same");
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, "st_tick_hold");
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, "st_tick_exp");
        // start wins over ack in DONE; start in RUN ignored
        step(0, 1, 0, 1, 5, 0, 1, 0, 0, 5, "done_start_ack");
        step(0, 1, 0, 0, 9, 0, 1, 0, 0, 5, "run_start_ign");
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "run_stop");

        // reset mid-count
        step(0, 1, 0, 0, 200, 0, 1, 0, 0, 200, "rst_start");
        for (int i = 1; i <= 50; i++)
            step(1, 0, 0, 0, 0, 0, 1, 0, 0, 8'(200 - i), "rst_count");
        tick = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        push(0, 0, 0, 0, "rst_async");
        pop_check();
        @(negedge CLOCK_50);
        resetn = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_after1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_after2");

`ifdef TICK_TIMER_PAUSE_EN
        step(0, 1, 0, 0, 4, 0, 1, 0, 0, 4, "pz_start");
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 3, "pz_tick");
        pause = 1'b1;
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 0, 0, 1, 0, 0, 3, "pz_held");
        pause = 1'b0;
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 2, "pz_res1");
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, "pz_res2");
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, "pz_exp");
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "pz_ack");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
